// File: rtl/ecc_decode_arbiter.sv
// Round-robin arbiter that lends a single ECC decode engine to two NAND
// channels. One job at a time: load IN_WORDS words, decode, unload OUT_WORDS.
module ecc_decode_arbiter #(
  parameter int IN_WORDS  = 288,
  parameter int OUT_WORDS = 256,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_req,
  output logic        ch0_grant,
  input  logic        ch0_wr_valid,
  input  logic [31:0] ch0_wr_data,
  output logic        ch0_wr_ready,
  input  logic        ch0_rd_ready,
  output logic        ch0_rd_valid,
  output logic        ch0_done,
  output logic        ch0_fail,
  input  logic        ch1_req,
  output logic        ch1_grant,
  input  logic        ch1_wr_valid,
  input  logic [31:0] ch1_wr_data,
  output logic        ch1_wr_ready,
  input  logic        ch1_rd_ready,
  output logic        ch1_rd_valid,
  output logic        ch1_done,
  output logic        ch1_fail,
  output logic [31:0] rd_data,
  output logic        eng_req,
  input  logic        eng_rdy,
  output logic        eng_wr_en,
  output logic [31:0] eng_data_in,
  output logic        eng_rd_en,
  input  logic [31:0] eng_data_out,
  input  logic        eng_decode_over,
  input  logic        eng_decode_result,
  input  logic        eng_output_over
);

  localparam int MAXW = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] IN_LAST = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] OUT_N   = CW'(OUT_WORDS);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_DECODE, S_UNLOAD, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic          gnt, gnt_nx;    // 0 = ch0 owns the engine, 1 = ch1
  logic          last_grant;
  logic [CW-1:0] wcnt;           // words loaded, then reads issued
  logic [CW-1:0] ccnt;           // unload words consumed by the channel
  logic [TW-1:0] tcnt;
  logic          result, tmo, out_over, inflight, hold;

  logic          g_wr_valid, g_rd_ready, load_acc, consume, rd_issue;
  logic [31:0]   g_wr_data;

  assign g_wr_valid = gnt ? ch1_wr_valid : ch0_wr_valid;
  assign g_wr_data  = gnt ? ch1_wr_data  : ch0_wr_data;
  assign g_rd_ready = gnt ? ch1_rd_ready : ch0_rd_ready;
  assign load_acc   = (state == S_LOAD) & g_wr_valid;
  assign consume    = (state == S_UNLOAD) & hold & g_rd_ready;
  // One read in flight; refill the holding register as it drains.
  assign rd_issue   = (state == S_UNLOAD) & (~hold | consume) & ~inflight & (wcnt < OUT_N);

  // Next-state, grant selection and decoded outputs.
  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    ch0_grant    = 1'b0;
    ch1_grant    = 1'b0;
    ch0_wr_ready = 1'b0;
    ch1_wr_ready = 1'b0;
    ch0_rd_valid = 1'b0;
    ch1_rd_valid = 1'b0;
    ch0_done     = 1'b0;
    ch1_done     = 1'b0;
    ch0_fail     = 1'b0;
    ch1_fail     = 1'b0;
    eng_req      = 1'b0;
    eng_wr_en    = load_acc;
    eng_data_in  = 32'd0;
    eng_rd_en    = rd_issue;
    if (state != S_IDLE) begin
      ch0_grant = ~gnt;
      ch1_grant = gnt;
    end
    case (state)
      S_IDLE: begin
        if (ch0_req | ch1_req) begin
          state_nx = S_REQ;
          gnt_nx   = (ch0_req & ch1_req) ? ~last_grant : ch1_req;
        end
      end
      S_REQ: begin
        eng_req = 1'b1;
        if (eng_rdy) state_nx = S_LOAD;
      end
      S_LOAD: begin
        ch0_wr_ready = ~gnt;
        ch1_wr_ready = gnt;
        eng_data_in  = g_wr_data;
        if (load_acc && wcnt == IN_LAST) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (eng_decode_over)     state_nx = S_UNLOAD;
        else if (tcnt == T_LAST) state_nx = S_DONE;
      end
      S_UNLOAD: begin
        ch0_rd_valid = hold & ~gnt;
        ch1_rd_valid = hold & gnt;
        if (ccnt == OUT_N && (out_over || eng_output_over)) state_nx = S_DONE;
      end
      S_DONE: begin
        ch0_done = ~gnt;
        ch1_done = gnt;
        ch0_fail = ~gnt & (~result | tmo);
        ch1_fail = gnt & (~result | tmo);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, counters, result latch and unload holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wcnt       <= '0;
      ccnt       <= '0;
      tcnt       <= '0;
      result     <= 1'b0;
      tmo        <= 1'b0;
      out_over   <= 1'b0;
      inflight   <= 1'b0;
      hold       <= 1'b0;
      rd_data    <= 32'd0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      case (state)
        S_REQ:  if (eng_rdy) wcnt <= '0;
        S_LOAD: if (load_acc) wcnt <= wcnt + 1'b1;
        S_DECODE: begin
          tcnt <= tcnt + 1'b1;
          if (eng_decode_over) begin
            result <= eng_decode_result;
            wcnt   <= '0;
          end else if (tcnt == T_LAST) begin
            tmo <= 1'b1;
          end
        end
        S_UNLOAD: begin
          inflight <= rd_issue;
          if (rd_issue) wcnt <= wcnt + 1'b1;
          // Capture the word returned one cycle after the read strobe.
          if (inflight) begin
            rd_data <= eng_data_out;
            hold    <= 1'b1;
          end else if (consume) begin
            hold <= 1'b0;
          end
          if (consume) ccnt <= ccnt + 1'b1;
          if (eng_output_over) out_over <= 1'b1;
        end
        S_DONE: begin
          last_grant <= gnt;
          wcnt       <= '0;
          ccnt       <= '0;
          tcnt       <= '0;
          result     <= 1'b0;
          tmo        <= 1'b0;
          out_over   <= 1'b0;
          inflight   <= 1'b0;
          hold       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_decode_arbiter.sv
// Bench for ecc_decode_arbiter: behavioural decode engine plus two channel
// drivers; unload words are checked through a per-job expected-word queue.
module tb_ecc_decode_arbiter;

  localparam int IN_W    = 288;
  localparam int OUT_W   = 256;
  localparam int TMO     = 50;
  localparam int DEC_LAT = 20;   // engine decode latency, well inside TMO

  logic        clk, rst;
  logic [1:0]  req, wr_valid, rd_ready;
  logic [31:0] wr_data [2];
  wire  [1:0]  grant, wr_ready, rd_valid, done, fail;
  wire  [31:0] rd_data, eng_data_in;
  wire         eng_req, eng_wr_en, eng_rd_en;
  logic        eng_rdy, eng_decode_over, eng_decode_result, eng_output_over;
  logic [31:0] eng_data_out;

  int checks = 0, failures = 0;
  int wr_total = 0, rd_total = 0, overlap = 0, g1_cnt = 0;
  bit cfg_result = 1'b1, cfg_no_decode = 1'b0;
  logic [31:0] load_exp_q[$];
  int serve_q[$];

  ecc_decode_arbiter #(.IN_WORDS(IN_W), .OUT_WORDS(OUT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ch0_req(req[0]), .ch0_grant(grant[0]), .ch0_wr_valid(wr_valid[0]),
    .ch0_wr_data(wr_data[0]), .ch0_wr_ready(wr_ready[0]), .ch0_rd_ready(rd_ready[0]),
    .ch0_rd_valid(rd_valid[0]), .ch0_done(done[0]), .ch0_fail(fail[0]),
    .ch1_req(req[1]), .ch1_grant(grant[1]), .ch1_wr_valid(wr_valid[1]),
    .ch1_wr_data(wr_data[1]), .ch1_wr_ready(wr_ready[1]), .ch1_rd_ready(rd_ready[1]),
    .ch1_rd_valid(rd_valid[1]), .ch1_done(done[1]), .ch1_fail(fail[1]),
    .rd_data(rd_data), .eng_req(eng_req), .eng_rdy(eng_rdy), .eng_wr_en(eng_wr_en),
    .eng_data_in(eng_data_in), .eng_rd_en(eng_rd_en), .eng_data_out(eng_data_out),
    .eng_decode_over(eng_decode_over), .eng_decode_result(eng_decode_result),
    .eng_output_over(eng_output_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (grant[1]) g1_cnt++;

  // Behavioural decode engine: rdy a few cycles after req, fixed decode
  // latency, returns 0xA5000000 + index one cycle after each read strobe.
  typedef enum {E_IDLE, E_WAIT, E_LOAD, E_DEC, E_UNL} est_t;
  est_t es;
  int   ecnt;
  logic rd_en_d;
  logic [31:0] lexp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      es <= E_IDLE; ecnt <= 0; rd_en_d <= 1'b0; eng_rdy <= 1'b0;
      eng_decode_over <= 1'b0; eng_decode_result <= 1'b0;
      eng_output_over <= 1'b0; eng_data_out <= 32'd0;
    end else begin
      eng_decode_over <= 1'b0;
      eng_output_over <= 1'b0;
      rd_en_d         <= eng_rd_en;
      if (eng_wr_en) begin
        wr_total++;
        checks++;
        lexp = (load_exp_q.size() != 0) ? load_exp_q.pop_front() : 32'hDEAD_BEEF;
        if (eng_data_in !== lexp)
          $display("FAIL load_word: eng_data_in=%h required %h", eng_data_in, lexp);
        if (eng_data_in !== lexp) failures++;
      end
      if (eng_rd_en) begin
        rd_total++;
        if (rd_en_d) overlap++;
      end
      if (eng_req && es != E_WAIT) begin
        es <= E_WAIT; ecnt <= 0;
      end else begin
        case (es)
          E_WAIT: begin
            ecnt <= ecnt + 1;
            if (ecnt == 2) eng_rdy <= 1'b1;
            if (eng_rdy && eng_req) begin eng_rdy <= 1'b0; es <= E_LOAD; ecnt <= 0; end
          end
          E_LOAD: if (eng_wr_en) begin
            ecnt <= ecnt + 1;
            if (ecnt == IN_W - 1) begin es <= E_DEC; ecnt <= 0; end
          end
          E_DEC: if (!cfg_no_decode) begin
            ecnt <= ecnt + 1;
            if (ecnt == DEC_LAT - 1) begin
              eng_decode_over <= 1'b1; eng_decode_result <= cfg_result;
              es <= E_UNL; ecnt <= 0;
            end
          end
          E_UNL: if (eng_rd_en) begin
            eng_data_out <= 32'hA500_0000 + 32'(ecnt);
            ecnt <= ecnt + 1;
            if (ecnt == OUT_W - 1) begin eng_output_over <= 1'b1; es <= E_IDLE; end
          end
          default: ;
        endcase
      end
    end
  end

  // One complete job from channel ch. rdmode 1 toggles rd_ready every 3
  // cycles; abort_at >= 0 asserts rst after that many unload words.
  task automatic run_job(input int ch, input int job, input bit hold, input int rdmode,
                         input bit exp_fail, input bit exp_tmo, input int abort_at);
    int cyc = 0, idx = 0, got = 0, dec_cyc = -1, gw = 0;
    bit pend = 0, done_seen = 0, aborted = 0, rdy;
    logic [31:0] pend_data = 0, exp_w, pat;
    logic [31:0] word_exp[$];
    if (!exp_tmo) for (int i = 0; i < OUT_W; i++) word_exp.push_back(32'hA500_0000 + 32'(i));
    @(negedge clk);
    req[ch] = 1'b1;
    while (!grant[ch] && gw < 5000) begin @(negedge clk); gw++; end
    checks++;
    if (!grant[ch]) begin
      failures++;
      $display("FAIL grant_wait ch%0d: grant=%b required 1", ch, grant[ch]);
      req[ch] = 1'b0;
      return;
    end
    if (!hold) req[ch] = 1'b0;
    while (!done_seen && !aborted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (wr_ready[1-ch] || rd_valid[1-ch]) begin
        failures++;
        $display("FAIL other_ch idle: wr_ready=%b rd_valid=%b required 0", wr_ready[1-ch], rd_valid[1-ch]);
      end
      if (pend) begin
        checks++;
        if (!rd_valid[ch] || rd_data !== pend_data) begin
          failures++;
          $display("FAIL hold_stable ch%0d: rd_valid=%b rd_data=%h required 1 %h", ch, rd_valid[ch], rd_data, pend_data);
        end
      end
      if (done[ch]) begin
        done_seen = 1;
        serve_q.push_back(ch);
        checks++;
        if (fail[ch] !== exp_fail) begin
          failures++;
          $display("FAIL done_fail ch%0d: fail=%b required %b", ch, fail[ch], exp_fail);
        end
        checks++;
        if (word_exp.size() != 0 || got != (exp_tmo ? 0 : OUT_W)) begin
          failures++;
          $display("FAIL word_count ch%0d: got=%0d required %0d", ch, got, exp_tmo ? 0 : OUT_W);
        end
        if (exp_tmo) begin
          checks++;
          if (cyc - dec_cyc != TMO) begin
            failures++;
            $display("FAIL timeout_latency: cycles=%0d required %0d", cyc - dec_cyc, TMO);
          end
        end
      end
      if (idx == IN_W && dec_cyc < 0 && !wr_ready[ch]) dec_cyc = cyc;
      rdy = (rdmode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      rd_ready[ch] = rdy;
      if (rd_valid[ch] && rdy) begin
        checks++;
        exp_w = (word_exp.size() != 0) ? word_exp.pop_front() : 32'hDEAD_BEEF;
        if (rd_data !== exp_w) begin
          failures++;
          $display("FAIL unload_word ch%0d #%0d: rd_data=%h required %h", ch, got, rd_data, exp_w);
        end
        got++;
        pend = 0;
      end else begin
        pend = rd_valid[ch];
        pend_data = rd_data;
      end
      if (wr_ready[ch] && idx < IN_W && (cyc % 7) != 3) begin
        pat = {8'(ch), 8'(job), 16'(idx)};
        wr_valid[ch] = 1'b1;
        wr_data[ch]  = pat;
        load_exp_q.push_back(pat);
        idx++;
      end else begin
        wr_valid[ch] = 1'b0;
      end
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1; req = 2'b00; wr_valid = 2'b00; rd_ready = 2'b00;
        #1;
        checks++;
        if ({grant, wr_ready, rd_valid, done, fail, eng_req, eng_wr_en, eng_rd_en, rd_data, eng_data_in} !== '0) begin
          failures++;
          $display("FAIL reset_mid_job outputs: grant=%b rd_valid=%b rd_data=%h required all 0", grant, rd_valid, rd_data);
        end
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (done !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_done: done=%b required 00", done);
          end
        end
        rst = 1'b0;
        aborted = 1;
      end
    end
    if (!done_seen && !aborted) begin
      checks++;
      failures++;
      $display("FAIL job_timeout ch%0d: no done after %0d cycles", ch, cyc);
    end
    wr_valid[ch] = 1'b0;
    rd_ready[ch] = 1'b0;
    if (done_seen) begin
      @(negedge clk);
      checks++;
      if (done[ch] !== 1'b0 || grant[ch] !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse ch%0d: done=%b grant=%b required 0 0", ch, done[ch], grant[ch]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; wr_valid = 2'b00; rd_ready = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 2'b00; wr_valid = 2'b00; rd_ready = 2'b00;
    wr_data[0] = 32'd0; wr_data[1] = 32'd0;
    #2 rst = 1'b1;
    req = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, wr_ready, rd_valid, done, fail, eng_req, eng_wr_en, eng_rd_en, rd_data, eng_data_in} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b eng_req=%b rd_data=%h required all 0", grant, eng_req, rd_data);
    end
    req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_ch0();
    int wr0 = wr_total, rd0 = rd_total, g0 = g1_cnt;
    run_job(0, 1, 1'b0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (wr_total - wr0 != IN_W) begin
      failures++;
      $display("FAIL single_wr_count: eng_wr_en=%0d required %0d", wr_total - wr0, IN_W);
    end
    checks++;
    if (rd_total - rd0 != OUT_W) begin
      failures++;
      $display("FAIL single_rd_count: eng_rd_en=%0d required %0d", rd_total - rd0, OUT_W);
    end
    checks++;
    if (g1_cnt != g0) begin
      failures++;
      $display("FAIL single_ch1_grant: ch1 grant cycles=%0d required 0", g1_cnt - g0);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 0, 1};
    do_reset();
    serve_q.delete();
    fork
      begin run_job(0, 2, 1'b1, 0, 1'b0, 1'b0, -1); run_job(0, 3, 1'b0, 0, 1'b0, 1'b0, -1); end
      begin run_job(1, 4, 1'b1, 0, 1'b0, 1'b0, -1); run_job(1, 5, 1'b0, 0, 1'b0, 1'b0, -1); end
    join
    checks++;
    if (serve_q.size() != 4) begin
      failures++;
      $display("FAIL rr_jobs: served=%0d required 4", serve_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (serve_q[i] != exp_order[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: ch=%0d required %0d", i, serve_q[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_decode_fail();
    cfg_result = 1'b0;
    run_job(1, 6, 1'b0, 0, 1'b1, 1'b0, -1);
    cfg_result = 1'b1;
  endtask

  task automatic test_timeout();
    int rd0 = rd_total;
    cfg_no_decode = 1'b1;
    run_job(0, 7, 1'b0, 0, 1'b1, 1'b1, -1);
    cfg_no_decode = 1'b0;
    checks++;
    if (rd_total != rd0) begin
      failures++;
      $display("FAIL timeout_no_read: eng_rd_en=%0d required 0", rd_total - rd0);
    end
  endtask

  task automatic test_backpressure();
    run_job(1, 8, 1'b0, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_job();
    int wr0;
    run_job(1, 9, 1'b0, 0, 1'b0, 1'b0, 100);
    wr0 = wr_total;
    run_job(1, 10, 1'b0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (wr_total - wr0 != IN_W) begin
      failures++;
      $display("FAIL restart_wr_count: eng_wr_en=%0d required %0d", wr_total - wr0, IN_W);
    end
  endtask

  initial begin
    test_reset();
    test_single_ch0();
    test_round_robin();
    test_decode_fail();
    test_timeout();
    test_backpressure();
    test_reset_mid_job();
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL reads_in_flight: back-to-back eng_rd_en=%0d required 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
